hcp_reg_bank_param: RTL and testbench



---
 rtl/hcp_reg_pkg.sv | 23 ++
 rtl/hcp_event_cnt.sv | 27 ++
 rtl/hcp_reg_bank_param.sv | 141 ++++++++++++++
 tb/tb_hcp_reg_bank_param.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hcp_reg_pkg.sv
// Shared constants for the HCP register bank: fixed word offsets, default
// identity values, and helpers for the NUM_RW-dependent sticky/counter offsets.
package hcp_reg_pkg;

  localparam int OFF_ID        = 0;
  localparam int OFF_VER       = 1;
  localparam int OFF_MID       = 2;
  localparam int OFF_TSS_VER   = 3;
  localparam int OFF_CTRL_BASE = 4;

  localparam logic [15:0] DEF_VENDOR_ID = 16'h0000;
  localparam logic [15:0] DEF_DEVICE_ID = 16'h0000;
  localparam logic [31:0] DEF_HCP_VER   = 32'h0000_3410;

  function automatic int sts_offset(input int num_rw);
    return OFF_CTRL_BASE + num_rw;
  endfunction

  function automatic int cnt_offset(input int num_rw, input int idx);
    return sts_offset(num_rw) + 1 + idx;
  endfunction

endpackage

// File: rtl/hcp_event_cnt.sv
// Single saturating event counter; clear takes priority but a coincident
// increment is still counted, so clear+inc leaves the counter at 1.
module hcp_event_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] ov_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= CNT_W'(i_inc);
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign ov_cnt = r_cnt;

endmodule

// File: rtl/hcp_reg_bank_param.sv
// Parametrised HCP register bank: ID/version words, RW control words, W1C sticky
// status and saturating event counters. Optional macro HCP_CNT_READ_CLEAR_EN.
module hcp_reg_bank_param
  import hcp_reg_pkg::*;
#(
  parameter logic [18:0] BASE_ADDR = 19'd0,
  parameter logic [15:0] VENDOR_ID = DEF_VENDOR_ID,
  parameter logic [15:0] DEVICE_ID = DEF_DEVICE_ID,
  parameter logic [31:0] HCP_VER   = DEF_HCP_VER,
  parameter int          NUM_RW    = 4,
  parameter int          STS_W     = 8,
  parameter int          NUM_CNT   = 4,
  parameter int          CNT_W     = 32
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic [11:0]                           iv_hcp_mid,
  input  logic [11:0]                           iv_tsnlight_mid,
  input  logic [31:0]                           iv_tss_ver,
  input  logic [18:0]                           iv_addr,
  input  logic                                  i_addr_fixed,
  input  logic [31:0]                           iv_wdata,
  input  logic                                  i_wr,
  input  logic                                  i_rd,
  output logic                                  o_wr,
  output logic [18:0]                           ov_addr,
  output logic                                  o_addr_fixed,
  output logic [31:0]                           ov_rdata,
  output logic [NUM_RW*32-1:0]                  ov_ctrl,
  output logic [NUM_RW-1:0]                     ov_ctrl_wr,
  input  logic [STS_W-1:0]                      iv_sts_set,
  output logic [STS_W-1:0]                      ov_sts,
  input  logic [((NUM_CNT > 0) ? NUM_CNT : 1)-1:0] iv_cnt_inc
);

  localparam int S_OFF    = sts_offset(NUM_RW);
  localparam int LAST_OFF = S_OFF + NUM_CNT;
  localparam int NC       = (NUM_CNT > 0) ? NUM_CNT : 1;

  logic [18:0]          w_offset;
  logic                 w_req_ok;
  logic                 w_rd_hit;
  logic                 w_wr_hit;
  logic [31:0]          w_rdata;
  logic [NUM_RW-1:0]    w_ctrl_we;
  logic [STS_W-1:0]     w_sts_clr;
  logic [NC-1:0]        w_cnt_clr;
  logic [CNT_W-1:0]     w_cnt [NC];

  logic [NUM_RW*32-1:0] r_ctrl;
  logic [NUM_RW-1:0]    r_ctrl_wr;
  logic [STS_W-1:0]     r_sts;
  logic                 r_rsp_vld;
  logic [18:0]          r_rsp_addr;
  logic                 r_rsp_fixed;
  logic [31:0]          r_rsp_data;

  // Offsets below BASE_ADDR wrap to large values and fall outside the window.
  assign w_offset = iv_addr - BASE_ADDR;
  assign w_req_ok = !i_addr_fixed && (w_offset <= 19'(LAST_OFF));
  assign w_rd_hit = i_rd && !i_wr && w_req_ok;
  assign w_wr_hit = i_wr && w_req_ok;

  always_comb begin
    w_rdata = '0;
    if (w_offset == 19'(OFF_ID))      w_rdata = {DEVICE_ID, VENDOR_ID};
    if (w_offset == 19'(OFF_VER))     w_rdata = HCP_VER;
    if (w_offset == 19'(OFF_MID))     w_rdata = {8'h00, iv_tsnlight_mid, iv_hcp_mid};
    if (w_offset == 19'(OFF_TSS_VER)) w_rdata = iv_tss_ver;
    for (int k = 0; k < NUM_RW; k++) begin
      if (w_offset == 19'(OFF_CTRL_BASE + k)) w_rdata = r_ctrl[32*k +: 32];
    end
    if (w_offset == 19'(S_OFF)) w_rdata = 32'(r_sts);
    for (int i = 0; i < NUM_CNT; i++) begin
      if (w_offset == 19'(cnt_offset(NUM_RW, i))) w_rdata = 32'(w_cnt[i]);
    end
  end

  always_comb begin
    w_ctrl_we = '0;
    w_sts_clr = '0;
    w_cnt_clr = '0;
    for (int k = 0; k < NUM_RW; k++) begin
      if (w_wr_hit && (w_offset == 19'(OFF_CTRL_BASE + k))) w_ctrl_we[k] = 1'b1;
    end
    if (w_wr_hit && (w_offset == 19'(S_OFF))) w_sts_clr = iv_wdata[STS_W-1:0];
`ifdef HCP_CNT_READ_CLEAR_EN
    for (int i = 0; i < NUM_CNT; i++) begin
      if (w_rd_hit && (w_offset == 19'(cnt_offset(NUM_RW, i)))) w_cnt_clr[i] = 1'b1;
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ctrl      <= '0;
      r_ctrl_wr   <= '0;
      r_sts       <= '0;
      r_rsp_vld   <= 1'b0;
      r_rsp_addr  <= '0;
      r_rsp_fixed <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_ctrl_wr <= w_ctrl_we;
      for (int k = 0; k < NUM_RW; k++) begin
        if (w_ctrl_we[k]) r_ctrl[32*k +: 32] <= iv_wdata;
      end
      // Set is OR-ed after the clear so a coincident set always wins.
      r_sts       <= (r_sts & ~w_sts_clr) | iv_sts_set;
      r_rsp_vld   <= w_rd_hit;
      r_rsp_addr  <= w_rd_hit ? iv_addr : '0;
      r_rsp_fixed <= w_rd_hit & i_addr_fixed;
      r_rsp_data  <= w_rd_hit ? w_rdata : '0;
    end
  end

  generate
    if (NUM_CNT > 0) begin : g_cnt
      for (genvar i = 0; i < NUM_CNT; i++) begin : g_inst
        hcp_event_cnt #(.CNT_W(CNT_W)) u_cnt (
          .i_clk   (i_clk),
          .i_rst_n (i_rst_n),
          .i_inc   (iv_cnt_inc[i]),
          .i_clr   (w_cnt_clr[i]),
          .ov_cnt  (w_cnt[i])
        );
      end
    end else begin : g_no_cnt
      assign w_cnt[0] = '0;
    end
  endgenerate

  assign o_wr         = r_rsp_vld;
  assign ov_addr      = r_rsp_addr;
  assign o_addr_fixed = r_rsp_fixed;
  assign ov_rdata     = r_rsp_data;
  assign ov_ctrl      = r_ctrl;
  assign ov_ctrl_wr   = r_ctrl_wr;
  assign ov_sts       = r_sts;

endmodule

// File: tb/tb_hcp_reg_bank_param.sv
// Randomised self-checking bench for hcp_reg_bank_param against an array-based
// register-map model; honours HCP_CNT_READ_CLEAR_EN when it is defined.
module tb_hcp_reg_bank_param;

  localparam logic [18:0] BASE = 19'h00100;
  localparam int NRW   = 4;
  localparam int SW    = 8;
  localparam int NCNT  = 4;
  localparam int CW    = 8;
  localparam int S_OFF = 4 + NRW;
  localparam int CNT0  = S_OFF + 1;
  localparam int LAST  = S_OFF + NCNT;
  localparam int CMAX  = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rstN;
  logic [11:0]       hcpMid, tsnMid;
  logic [31:0]       tssVer;
  logic [18:0]       addr;
  logic              addrFixed;
  logic [31:0]       wdata;
  logic              wr, rd;
  logic              rspWr;
  logic [18:0]       rspAddr;
  logic              rspFixed;
  logic [31:0]       rdata;
  logic [NRW*32-1:0] ctrl;
  logic [NRW-1:0]    ctrlWr;
  logic [SW-1:0]     stsSet, sts;
  logic [NCNT-1:0]   cntInc;

  int errors = 0;
  int checks = 0;

  logic [31:0]    mCtrl [NRW];
  logic [SW-1:0]  mSts;
  int             mCnt [NCNT];
  logic           eWr;
  logic [18:0]    eAddr;
  logic [31:0]    eData;
  logic [NRW-1:0] eCtrlWr;

  hcp_reg_bank_param #(
    .BASE_ADDR (BASE),
    .VENDOR_ID (16'h0001),
    .DEVICE_ID (16'h0002),
    .HCP_VER   (32'h0000_3410),
    .NUM_RW    (NRW),
    .STS_W     (SW),
    .NUM_CNT   (NCNT),
    .CNT_W     (CW)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rstN),
    .iv_hcp_mid      (hcpMid),
    .iv_tsnlight_mid (tsnMid),
    .iv_tss_ver      (tssVer),
    .iv_addr         (addr),
    .i_addr_fixed    (addrFixed),
    .iv_wdata        (wdata),
    .i_wr            (wr),
    .i_rd            (rd),
    .o_wr            (rspWr),
    .ov_addr         (rspAddr),
    .o_addr_fixed    (rspFixed),
    .ov_rdata        (rdata),
    .ov_ctrl         (ctrl),
    .ov_ctrl_wr      (ctrlWr),
    .iv_sts_set      (stsSet),
    .ov_sts          (sts),
    .iv_cnt_inc      (cntInc)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] modelRead(input int off);
    if (off == 0) return 32'h0002_0001;
    if (off == 1) return 32'h0000_3410;
    if (off == 2) return {8'h00, tsnMid, hcpMid};
    if (off == 3) return tssVer;
    if (off >= 4 && off < 4 + NRW) return mCtrl[off-4];
    if (off == S_OFF) return 32'(mSts);
    if (off >= CNT0 && off <= LAST) return 32'(mCnt[off-CNT0]);
    return 32'h0;
  endfunction

  function automatic logic [NRW*32-1:0] packCtrl();
    logic [NRW*32-1:0] p;
    for (int k = 0; k < NRW; k++) p[32*k +: 32] = mCtrl[k];
    return p;
  endfunction

  task automatic resetModel();
    for (int k = 0; k < NRW; k++) mCtrl[k] = '0;
    for (int i = 0; i < NCNT; i++) mCnt[i] = 0;
    mSts = '0;
  endtask

  // Drive one cycle of request, advance the model, and compare after the edge.
  task automatic applyStimulus(input logic iRd, input logic iWr, input logic [18:0] iAddr,
                               input logic iFixed, input logic [31:0] iData,
                               input logic [SW-1:0] iSet, input logic [NCNT-1:0] iInc);
    logic [18:0]   diff;
    int            off;
    logic          hit, rdHit, rc;
    logic [SW-1:0] clr;
    rd = iRd; wr = iWr; addr = iAddr; addrFixed = iFixed;
    wdata = iData; stsSet = iSet; cntInc = iInc;
    diff  = iAddr - BASE;
    off   = int'(diff);
    hit   = !iFixed && (off <= LAST);
    rdHit = iRd && !iWr && hit;
    eWr   = rdHit;
    eAddr = rdHit ? iAddr : 19'h0;
    eData = rdHit ? modelRead(off) : 32'h0;
    eCtrlWr = '0;
    if (iWr && hit && off >= 4 && off < 4 + NRW) begin
      mCtrl[off-4]   = iData;
      eCtrlWr[off-4] = 1'b1;
    end
    clr  = (iWr && hit && off == S_OFF) ? iData[SW-1:0] : '0;
    mSts = (mSts & ~clr) | iSet;
    for (int i = 0; i < NCNT; i++) begin
      rc = 1'b0;
`ifdef HCP_CNT_READ_CLEAR_EN
      rc = rdHit && (off == CNT0 + i);
`endif
      if (rc) mCnt[i] = iInc[i] ? 1 : 0;
      else if (iInc[i] && mCnt[i] < CMAX) mCnt[i] = mCnt[i] + 1;
    end
    @(posedge clk);
    #1;
    checkOutput("o_wr", 128'(rspWr), 128'(eWr));
    checkOutput("ov_addr", 128'(rspAddr), 128'(eAddr));
    checkOutput("o_addr_fixed", 128'(rspFixed), 128'(1'b0));
    checkOutput("ov_rdata", 128'(rdata), 128'(eData));
    checkOutput("ov_ctrl", 128'(ctrl), 128'(packCtrl()));
    checkOutput("ov_ctrl_wr", 128'(ctrlWr), 128'(eCtrlWr));
    checkOutput("ov_sts", 128'(sts), 128'(mSts));
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, BASE, 1'b0, 32'h0, '0, '0);
  endtask

  initial begin
    rstN = 1'b0;
    rd = 1'b0; wr = 1'b0; addr = '0; addrFixed = 1'b0;
    wdata = '0; stsSet = '0; cntInc = '0;
    hcpMid = 12'($urandom);
    tsnMid = 12'($urandom);
    tssVer = $urandom;
    resetModel();
    #12;
    checkOutput("rst_o_wr", 128'(rspWr), 128'(1'b0));
    checkOutput("rst_ov_rdata", 128'(rdata), 128'(32'h0));
    checkOutput("rst_ov_addr", 128'(rspAddr), 128'(19'h0));
    checkOutput("rst_ov_ctrl", 128'(ctrl), 128'h0);
    checkOutput("rst_ov_ctrl_wr", 128'(ctrlWr), 128'(4'h0));
    checkOutput("rst_ov_sts", 128'(sts), 128'(8'h0));
    @(negedge clk);
    rstN = 1'b1;

    // Identity and read-only words.
    applyStimulus(1'b1, 1'b0, BASE, 1'b0, 32'h0, '0, '0);
    checkOutput("id_word", 128'(rdata), 128'(32'h0002_0001));
    checkOutput("id_addr", 128'(rspAddr), 128'(BASE));
    applyStimulus(1'b1, 1'b0, BASE + 19'd1, 1'b0, 32'h0, '0, '0);
    checkOutput("ver_word", 128'(rdata), 128'(32'h0000_3410));
    applyStimulus(1'b1, 1'b0, BASE + 19'd2, 1'b0, 32'h0, '0, '0);
    applyStimulus(1'b1, 1'b0, BASE + 19'd3, 1'b0, 32'h0, '0, '0);

    // Control word 1 write, pulse and readback.
    applyStimulus(1'b0, 1'b1, BASE + 19'd5, 1'b0, 32'hA5A5_0003, '0, '0);
    checkOutput("ctrl1_pulse", 128'(ctrlWr), 128'(4'b0010));
    checkOutput("ctrl1_word", 128'(ctrl[63:32]), 128'(32'hA5A5_0003));
    idle();
    applyStimulus(1'b1, 1'b0, BASE + 19'd5, 1'b0, 32'h0, '0, '0);
    checkOutput("ctrl1_read", 128'(rdata), 128'(32'hA5A5_0003));

    // Sticky set/clear with set-wins.
    applyStimulus(1'b0, 1'b0, BASE, 1'b0, 32'h0, 8'h81, '0);
    applyStimulus(1'b0, 1'b1, BASE + 19'(S_OFF), 1'b0, 32'h01, 8'h01, '0);
    checkOutput("sts_set_wins", 128'(sts), 128'(8'h81));
    applyStimulus(1'b0, 1'b1, BASE + 19'(S_OFF), 1'b0, 32'h80, 8'h00, '0);
    checkOutput("sts_w1c", 128'(sts), 128'(8'h01));

    // Dropped requests: wr+rd, fixed space, out-of-window, below base, RO writes.
    applyStimulus(1'b1, 1'b1, BASE + 19'd4, 1'b0, 32'h1234_5678, '0, '0);
    checkOutput("wr_rd_ctrl0", 128'(ctrl[31:0]), 128'(32'h1234_5678));
    applyStimulus(1'b1, 1'b0, BASE + 19'd1, 1'b1, 32'h0, '0, '0);
    applyStimulus(1'b1, 1'b0, BASE + 19'd40, 1'b0, 32'h0, '0, '0);
    applyStimulus(1'b1, 1'b0, BASE - 19'd1, 1'b0, 32'h0, '0, '0);
    applyStimulus(1'b0, 1'b1, BASE + 19'd6, 1'b1, 32'hDEAD_BEEF, '0, '0);
    applyStimulus(1'b0, 1'b1, BASE + 19'(CNT0), 1'b0, 32'hFFFF_FFFF, '0, '0);
    applyStimulus(1'b0, 1'b1, BASE, 1'b0, 32'hFFFF_FFFF, '0, '0);

    // Counter 0 saturation.
    for (int n = 0; n < 300; n++)
      applyStimulus(1'b0, 1'b0, BASE, 1'b0, 32'h0, '0, {4'($urandom) & 4'b1110} | 4'b0001);
    applyStimulus(1'b1, 1'b0, BASE + 19'(CNT0), 1'b0, 32'h0, '0, '0);
    checkOutput("cnt0_sat", 128'(rdata), 128'(32'hFF));
    applyStimulus(1'b1, 1'b0, BASE + 19'(CNT0), 1'b0, 32'h0, '0, '0);
`ifdef HCP_CNT_READ_CLEAR_EN
    checkOutput("cnt0_after_clr", 128'(rdata), 128'(32'h0));
`else
    checkOutput("cnt0_still_sat", 128'(rdata), 128'(32'hFF));
`endif
    for (int i = 1; i < NCNT; i++)
      applyStimulus(1'b1, 1'b0, BASE + 19'(CNT0 + i), 1'b0, 32'h0, '0, 4'($urandom));

    // Randomised traffic over the window and beyond.
    for (int n = 0; n < 400; n++) begin
      int r;
      logic [18:0] a;
      r = $urandom_range(0, 15);
      a = (r < 14) ? BASE + 19'(r) : 19'($urandom);
      applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), a,
                    ($urandom_range(0, 7) == 0), $urandom,
                    ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00, 4'($urandom));
    end

    // Asynchronous reset in the cycle after a read hit.
    applyStimulus(1'b0, 1'b1, BASE + 19'd7, 1'b0, 32'h5555_AAAA, 8'h3C, 4'hF);
    applyStimulus(1'b1, 1'b0, BASE + 19'd7, 1'b0, 32'h0, '0, 4'hF);
    checkOutput("pre_rst_o_wr", 128'(rspWr), 128'(1'b1));
    #2;
    rstN = 1'b0;
    resetModel();
    #1;
    checkOutput("mid_rst_o_wr", 128'(rspWr), 128'(1'b0));
    checkOutput("mid_rst_rdata", 128'(rdata), 128'(32'h0));
    checkOutput("mid_rst_ctrl", 128'(ctrl), 128'h0);
    checkOutput("mid_rst_ctrl_wr", 128'(ctrlWr), 128'(4'h0));
    checkOutput("mid_rst_sts", 128'(sts), 128'(8'h0));
    @(negedge clk);
    rstN = 1'b1;
    for (int i = 0; i < NCNT; i++) begin
      applyStimulus(1'b1, 1'b0, BASE + 19'(CNT0 + i), 1'b0, 32'h0, '0, '0);
      checkOutput("cnt_after_rst", 128'(rdata), 128'(32'h0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
